// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access controller: one load/store per request over a
// req/ack handshake, pipeline stall while outstanding, store lane formatting.
module mem_access_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_valid,
  input  logic        i_mem_read,
  input  logic        i_mem_write,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_store_data,
  input  logic [2:0]  i_load_store_type,
  output logic        o_stall,
  output logic [31:0] o_mem_data,
  output logic [2:0]  o_load_store_type,
  output logic        o_data_valid,
  output logic        o_write_done,
  output logic        o_misaligned,
  output logic        o_timeout,
  output logic        o_dm_req,
  output logic        o_dm_we,
  output logic [31:0] o_dm_addr,
  output logic [3:0]  o_dm_be,
  output logic [31:0] o_dm_wdata,
  input  logic        i_dm_ack,
  input  logic [31:0] i_dm_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  localparam logic [7:0] LAST_COUNT = 8'(TIMEOUT_CYCLES - 1);

  state_t      state_q, state_d;
  logic [31:0] addr_q;
  logic        we_q;
  logic [2:0]  type_q;
  logic [3:0]  be_q;
  logic [31:0] wdata_q;
  logic [7:0]  count_q;

  logic        op;
  logic        misaligned;
  logic        timeout_hit;
  logic [3:0]  be_calc;
  logic [31:0] wdata_calc;
  logic [31:0] rdata_aligned;

  assign op          = i_valid & (i_mem_read | i_mem_write);
  assign timeout_hit = (count_q == LAST_COUNT);

  // Size code 2'b10 is treated as a word, so bit 1 alone selects word size.
  assign misaligned = ((i_load_store_type[1:0] == 2'b01) & i_addr[0])
                    | (i_load_store_type[1] & (|i_addr[1:0]));

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    be_calc    = 4'b1111;
    wdata_calc = '0;
    if (i_mem_write) begin
      case (i_load_store_type[1:0])
        2'b00: begin
          be_calc    = 4'b0001 << i_addr[1:0];
          wdata_calc = {4{i_store_data[7:0]}};
        end
        2'b01: begin
          be_calc    = 4'b0011 << {i_addr[1], 1'b0};
          wdata_calc = {2{i_store_data[15:0]}};
        end
        default: wdata_calc = i_store_data;
      endcase
    end
  end

  // Right-justify the addressed lane; upper bits are left for the extender.
  always_comb begin
    rdata_aligned = i_dm_rdata;
    case (type_q[1:0])
      2'b00:   rdata_aligned = i_dm_rdata >> {addr_q[1:0], 3'b000};
      2'b01:   rdata_aligned = i_dm_rdata >> {addr_q[1], 4'b0000};
      default: rdata_aligned = i_dm_rdata;
    endcase
  end

  always_comb begin
    state_d = state_q;
    o_stall = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (op) begin
          o_stall = 1'b1;
          state_d = misaligned ? S_DONE : S_BUSY;
        end
      end
      S_BUSY: begin
        o_stall = 1'b1;
        if (i_dm_ack || timeout_hit) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // sample the pre-edge values of each other.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      addr_q            <= '0;
      we_q              <= 1'b0;
      type_q            <= '0;
      be_q              <= '0;
      wdata_q           <= '0;
      count_q           <= '0;
      o_mem_data        <= '0;
      o_load_store_type <= '0;
      o_data_valid      <= 1'b0;
      o_write_done      <= 1'b0;
      o_misaligned      <= 1'b0;
      o_timeout         <= 1'b0;
    end else begin
      o_data_valid <= 1'b0;
      o_write_done <= 1'b0;
      o_misaligned <= 1'b0;
      o_timeout    <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (op) begin
            addr_q  <= i_addr;
            we_q    <= i_mem_write;
            type_q  <= i_load_store_type;
            be_q    <= be_calc;
            wdata_q <= wdata_calc;
            count_q <= '0;
            if (misaligned) begin
              o_misaligned      <= 1'b1;
              o_mem_data        <= '0;
              o_load_store_type <= i_load_store_type;
            end
          end
        end
        S_BUSY: begin
          // An ack in the limit cycle still counts as a normal completion.
          if (i_dm_ack) begin
            o_mem_data        <= rdata_aligned;
            o_load_store_type <= type_q;
            o_write_done      <= we_q;
            o_data_valid      <= ~we_q;
          end else if (timeout_hit) begin
            o_mem_data        <= '0;
            o_load_store_type <= type_q;
            o_timeout         <= 1'b1;
          end else begin
            count_q <= count_q + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_dm_req   = (state_q == S_BUSY);
  assign o_dm_we    = we_q;
  assign o_dm_addr  = {addr_q[31:2], 2'b00};
  assign o_dm_be    = be_q;
  assign o_dm_wdata = wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: stimulus pushes expected events,
// a negedge monitor pops them when a completion pulse appears.
module tb_mem_access_unit;

  localparam int unsigned TO = 4;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_valid, i_mem_read, i_mem_write;
  logic [31:0] i_addr, i_store_data;
  logic [2:0]  i_load_store_type;
  logic        o_stall;
  logic [31:0] o_mem_data;
  logic [2:0]  o_load_store_type;
  logic        o_data_valid, o_write_done, o_misaligned, o_timeout;
  logic        o_dm_req, o_dm_we;
  logic [31:0] o_dm_addr;
  logic [3:0]  o_dm_be;
  logic [31:0] o_dm_wdata;
  logic        i_dm_ack;
  logic [31:0] i_dm_rdata;

  mem_access_unit #(.TIMEOUT_CYCLES(TO)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid),
    .i_mem_read(i_mem_read), .i_mem_write(i_mem_write), .i_addr(i_addr),
    .i_store_data(i_store_data), .i_load_store_type(i_load_store_type),
    .o_stall(o_stall), .o_mem_data(o_mem_data),
    .o_load_store_type(o_load_store_type), .o_data_valid(o_data_valid),
    .o_write_done(o_write_done), .o_misaligned(o_misaligned),
    .o_timeout(o_timeout), .o_dm_req(o_dm_req), .o_dm_we(o_dm_we),
    .o_dm_addr(o_dm_addr), .o_dm_be(o_dm_be), .o_dm_wdata(o_dm_wdata),
    .i_dm_ack(i_dm_ack), .i_dm_rdata(i_dm_rdata)
  );

  always #5 i_clk = ~i_clk;

  typedef enum logic [1:0] {EV_DATA, EV_WRITE, EV_MIS, EV_TIMEOUT} ev_t;
  typedef struct {
    ev_t         kind;
    logic [31:0] data;
    logic [2:0]  typ;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic expect_ev(input ev_t kind, input logic [31:0] data, input logic [2:0] typ);
    exp_t e;
    e.kind = kind;
    e.data = data;
    e.typ  = typ;
    sb.push_back(e);
  endtask

  // Memory responder: acks in the ack_delay-th request cycle (never if <= 0).
  logic [31:0] mem [0:15];
  int          ack_delay = 0;
  int          run = 0;
  int          req_cycles = 0;
  int          req_total = 0;
  logic        unstable = 1'b0;
  logic        seen_we;
  logic [31:0] seen_addr, seen_wdata;
  logic [3:0]  seen_be;

  initial begin
    i_dm_ack   = 1'b0;
    i_dm_rdata = '0;
    forever begin
      @(posedge i_clk);
      #1;
      if (o_dm_req) begin
        run++;
        req_total++;
        req_cycles = run;
        if (run == 1) begin
          seen_we = o_dm_we; seen_addr = o_dm_addr;
          seen_be = o_dm_be; seen_wdata = o_dm_wdata;
        end else if (seen_we !== o_dm_we || seen_addr !== o_dm_addr ||
                     seen_be !== o_dm_be || seen_wdata !== o_dm_wdata) begin
          unstable = 1'b1;
        end
        if (ack_delay > 0 && run == ack_delay) begin
          i_dm_ack   = 1'b1;
          i_dm_rdata = mem[o_dm_addr[5:2]];
          if (o_dm_we) begin
            for (int b = 0; b < 4; b++)
              if (o_dm_be[b]) mem[o_dm_addr[5:2]][8*b +: 8] = o_dm_wdata[8*b +: 8];
          end
        end else begin
          i_dm_ack   = 1'b0;
          i_dm_rdata = '0;
        end
      end else begin
        run        = 0;
        i_dm_ack   = 1'b0;
        i_dm_rdata = '0;
      end
    end
  end

  // Monitor: exactly one completion pulse per popped expectation.
  always @(negedge i_clk) begin
    int   np;
    exp_t e;
    ev_t  act;
    if (i_rst_n) begin
      np = int'(o_data_valid) + int'(o_write_done) + int'(o_misaligned) + int'(o_timeout);
      if (np != 0) begin
        check("pulse_count", np, 1);
        if (sb.size() == 0) begin
          check("unexpected_pulse", 32'(np), 32'd0);
        end else begin
          e = sb.pop_front();
          act = o_misaligned ? EV_MIS : o_timeout ? EV_TIMEOUT : o_write_done ? EV_WRITE : EV_DATA;
          check("event_kind", 32'(act), 32'(e.kind));
          if (e.kind == EV_DATA || e.kind == EV_TIMEOUT)
            check("mem_data", o_mem_data, e.data);
          check("load_store_type", 32'(o_load_store_type), 32'(e.typ));
        end
      end
    end
  end

  task automatic issue(input logic rd, input logic wr, input logic [2:0] typ,
                       input logic [31:0] addr, input logic [31:0] sd, input int delay);
    @(posedge i_clk);
    #1;
    ack_delay         = delay;
    unstable          = 1'b0;
    i_valid           = 1'b1;
    i_mem_read        = rd;
    i_mem_write       = wr;
    i_load_store_type = typ;
    i_addr            = addr;
    i_store_data      = sd;
  endtask

  task automatic wait_done(output int n);
    logic done;
    done = 1'b0;
    n = 0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge i_clk);
      if (o_stall) n++;
      else done = 1'b1;
    end
    if (!done) check("stall_release_bound", 32'd0, 32'd1);
  endtask

  task automatic release_bus();
    @(posedge i_clk);
    #1;
    i_valid     = 1'b0;
    i_mem_read  = 1'b0;
    i_mem_write = 1'b0;
  endtask

  initial begin
    int n;
    int base_total;
    for (int i = 0; i < 16; i++) mem[i] = 32'h0;
    mem[0] = 32'h11223344;
    mem[1] = 32'h55667788;
    i_rst_n = 1'b0;
    i_valid = 1'b0; i_mem_read = 1'b0; i_mem_write = 1'b0;
    i_addr = '0; i_store_data = '0; i_load_store_type = '0;
    repeat (3) @(posedge i_clk);
    #1 i_rst_n = 1'b1;
    @(negedge i_clk);
    check("rst_stall", 32'(o_stall), 32'd0);
    check("rst_req", 32'(o_dm_req), 32'd0);
    check("rst_mem_data", o_mem_data, 32'd0);
    check("rst_type", 32'(o_load_store_type), 32'd0);
    check("rst_pulses", {o_data_valid, o_write_done, o_misaligned, o_timeout}, 32'd0);

    // LB at 0x102: byte 2 of 0x11223344 right-justified, ack in first req cycle.
    expect_ev(EV_DATA, 32'h00001122, 3'b000);
    issue(1'b1, 1'b0, 3'b000, 32'h0000_0102, 32'h0, 1);
    wait_done(n);
    check("lb_stall_cycles", n, 2);
    check("lb_dm_addr", seen_addr, 32'h0000_0100);
    check("lb_dm_be", 32'(seen_be), 32'hF);
    check("lb_dm_we", 32'(seen_we), 32'd0);
    release_bus();

    // SH at 0x106: ack lands in the cycle the timeout counter hits its limit.
    expect_ev(EV_WRITE, 32'h0, 3'b001);
    issue(1'b0, 1'b1, 3'b001, 32'h0000_0106, 32'hABCD1234, 4);
    wait_done(n);
    check("sh_stall_cycles", n, 5);
    check("sh_req_cycles", req_cycles, 4);
    check("sh_req_stable", 32'(unstable), 32'd0);
    check("sh_dm_be", 32'(seen_be), 32'hC);
    check("sh_dm_wdata", seen_wdata, 32'h12341234);
    check("sh_dm_addr", seen_addr, 32'h0000_0104);
    check("sh_dm_we", 32'(seen_we), 32'd1);
    release_bus();

    // LW at 0x101: rejected, memory never sees a request.
    base_total = req_total;
    expect_ev(EV_MIS, 32'h0, 3'b011);
    issue(1'b1, 1'b0, 3'b011, 32'h0000_0101, 32'h0, 1);
    wait_done(n);
    check("lw_mis_stall_cycles", n, 1);
    check("lw_mis_no_req", req_total, base_total);
    release_bus();

    // LHU at 0x100 with no ack: timeout after TO request cycles.
    expect_ev(EV_TIMEOUT, 32'h0, 3'b101);
    issue(1'b1, 1'b0, 3'b101, 32'h0000_0100, 32'h0, 0);
    wait_done(n);
    check("lhu_to_stall_cycles", n, 1 + TO);
    check("lhu_to_req_cycles", req_cycles, TO);
    #2 check("lhu_to_req_dropped", 32'(o_dm_req), 32'd0);
    release_bus();

    // Reset while BUSY: request and stall drop at once, no pulse follows.
    issue(1'b1, 1'b0, 3'b011, 32'h0000_0104, 32'h0, 0);
    @(negedge i_clk);
    @(negedge i_clk);
    check("busy_req_before_reset", 32'(o_dm_req), 32'd1);
    #2;
    i_rst_n = 1'b0;
    i_valid = 1'b0; i_mem_read = 1'b0;
    #1;
    check("reset_req_async", 32'(o_dm_req), 32'd0);
    check("reset_stall_async", 32'(o_stall), 32'd0);
    @(posedge i_clk);
    #1 i_rst_n = 1'b1;
    repeat (3) @(negedge i_clk);
    check("reset_no_pending", sb.size(), 0);

    // LW after reset sees the halfword written by the SH.
    expect_ev(EV_DATA, 32'h12347788, 3'b011);
    issue(1'b1, 1'b0, 3'b011, 32'h0000_0104, 32'h0, 2);
    wait_done(n);
    check("lw_stall_cycles", n, 3);

    // Back to back: read+write set resolves to a store, then LW of same word.
    expect_ev(EV_WRITE, 32'h0, 3'b011);
    issue(1'b1, 1'b1, 3'b011, 32'h0000_0108, 32'hDEADBEEF, 1);
    wait_done(n);
    check("sw_stall_cycles", n, 2);
    check("sw_dm_we", 32'(seen_we), 32'd1);
    check("sw_dm_wdata", seen_wdata, 32'hDEADBEEF);
    expect_ev(EV_DATA, 32'hDEADBEEF, 3'b011);
    issue(1'b1, 1'b0, 3'b011, 32'h0000_0108, 32'h0, 2);
    wait_done(n);
    check("lw_b2b_stall_cycles", n, 3);
    check("lw_b2b_dm_we", 32'(seen_we), 32'd0);

    // SB to the top lane, then LBU and LH over the modified word.
    expect_ev(EV_WRITE, 32'h0, 3'b000);
    issue(1'b0, 1'b1, 3'b000, 32'h0000_010B, 32'h000000A5, 1);
    wait_done(n);
    check("sb_dm_be", 32'(seen_be), 32'h8);
    check("sb_dm_wdata", seen_wdata, 32'hA5A5A5A5);
    expect_ev(EV_DATA, 32'h000000A5, 3'b100);
    issue(1'b1, 1'b0, 3'b100, 32'h0000_010B, 32'h0, 1);
    wait_done(n);
    expect_ev(EV_DATA, 32'h0000A5AD, 3'b001);
    issue(1'b1, 1'b0, 3'b001, 32'h0000_010A, 32'h0, 3);
    wait_done(n);
    check("lh_stall_cycles", n, 4);
    release_bus();

    repeat (5) @(negedge i_clk);
    check("scoreboard_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

MEM-stage data-memory access controller for the pipelined MIPS core. It sits between the EX/MEM pipeline register and the data memory, directly upstream of `load_instruction_type`. It runs one load or store per request over a req/ack memory handshake, freezes the pipeline while the access is outstanding, and builds byte enables and replicated write data for stores. For loads it right-justifies the addressed byte or halfword so `load_instruction_type` only has to extend.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, 15: number of BUSY cycles without `i_dm_ack` before the access is aborted. Range 1-255.

Ports (clock and reset first):
- `i_clk` in 1: single clock. All logic is rising-edge.
- `i_rst_n` in 1: asynchronous, active-low reset.
- `i_valid` in 1: EX/MEM holds a memory operation this cycle.
- `i_mem_read` in 1: the operation is a load.
- `i_mem_write` in 1: the operation is a store. If both this and `i_mem_read` are set, the store wins.
- `i_addr` in 32: byte address.
- `i_store_data` in 32: store source register; data is in the low bits.
- `i_load_store_type` in 3: bits [1:0] give size (00 byte, 01 half, 11 word; 10 is treated as word). Bit 2 means unsigned and is ignored for stores.
- `o_stall` out 1: combinational; freezes PC, IF/ID, ID/EX and EX/MEM.
- `o_mem_data` out 32: registered; right-justified load data, goes to `load_instruction_type.i_mem_data`.
- `o_load_store_type` out 3: registered copy of the latched type, for `load_instruction_type`.
- `o_data_valid` out 1: one-cycle pulse; load data is valid.
- `o_write_done` out 1: one-cycle pulse; store has completed.
- `o_misaligned` out 1: one-cycle pulse; access was rejected for misalignment.
- `o_timeout` out 1: one-cycle pulse; access was aborted after `TIMEOUT_CYCLES`.
- `o_dm_req` out 1: memory request. Held high until ack is seen.
- `o_dm_we` out 1: write enable.
- `o_dm_addr` out 32: word-aligned address, `{addr[31:2],2'b00}`.
- `o_dm_be` out 4: byte enables.
- `o_dm_wdata` out 32: write data.
- `i_dm_ack` in 1: memory has accepted the write or returned read data.
- `i_dm_rdata` in 32: read data, valid when `i_dm_ack` is high.

## Operation
- The FSM has three states: IDLE, BUSY and DONE. Reset puts it in IDLE with every registered output at 0.
- **Op present:** `op = i_valid & (i_mem_read | i_mem_write)`.
- **Misalignment:** a halfword is misaligned when `addr[0]=1`; a word is misaligned when `addr[1:0]≠0`. A byte access is never misaligned.
- **IDLE with an op:**
  - Latch the address, we, type, and the computed be/wdata.
  - If the op is aligned, go to BUSY. If it is misaligned, go straight to DONE with the misaligned flag set; the memory sees no access.
- **BUSY:**
  - Drive `o_dm_req=1`. Hold `o_dm_we`, `o_dm_addr`, `o_dm_be` and `o_dm_wdata` stable.
  - On `i_dm_ack=1`, capture the aligned read data and go to DONE. `o_dm_req` drops at the same edge.
  - The timeout counter is cleared on entry and counts every BUSY cycle. When it reaches `TIMEOUT_CYCLES`, go to DONE with the timeout flag set and capture data 0.
- **DONE:** lasts exactly one cycle and exactly one pulse fires:
  - `o_misaligned` if the access was misaligned, else
  - `o_timeout` if it timed out, else
  - `o_data_valid` for a load, or `o_write_done` for a store.
  - `i_valid` is ignored in DONE. That op is the one just served and leaves EX/MEM at this edge.
  - The next state is always IDLE.
- **`o_stall`:** `(IDLE & op) | BUSY`. It is 0 in DONE.
- **Store formatting:**
  - Byte: `be = 4'b0001 << addr[1:0]`, `wdata = {4{sd[7:0]}}`.
  - Half: `be = 4'b0011 << (2*addr[1])`, `wdata = {2{sd[15:0]}}`.
  - Word: `be = 4'b1111`, `wdata = sd`.
- **Load alignment:** applied to the captured data. Byte: `rdata >> (8*addr[1:0])`. Half: `rdata >> (16*addr[1])`. Word: unshifted. The bits above the size are not masked; `load_instruction_type` masks and extends them.
- For loads, `o_dm_be=4'b1111` and `o_dm_wdata=0`.
- **Reset mid-access:** asserting reset drops `o_dm_req` immediately and returns to IDLE, and no pulse is issued. The memory must tolerate an abandoned request.

## Timing
- Op seen in cycle T and ack in T+k (k≥1): stall is high for T..T+k, DONE is in T+k+1, and the pipeline advances at the end of T+k+1.
- Minimum latency is 2 stall cycles.
- Misaligned op: stall is high only in T; DONE with `o_misaligned` is in T+1; no `o_dm_req` is issued.
- Timeout: `o_dm_req` is high for T+1..T+TIMEOUT_CYCLES, and DONE is in T+TIMEOUT_CYCLES+1.
- An ack arriving in the same cycle the counter hits its limit counts as a normal completion, not a timeout.
- Back-to-back ops: a new op can be accepted in the IDLE cycle right after DONE.
- `o_mem_data` and `o_load_store_type` hold their values until the next DONE.

## Test plan
- LB with type 000 at addr 0x...02, memory returns 0x11223344 with ack 1 cycle after req → `o_mem_data[7:0]=0x22`, `o_data_valid` pulses in T+2, stall is high for 2 cycles.
- SH with type 001 at addr 0x...06, `sd=0xABCD1234`, ack delayed 3 cycles → `be=4'b1100`, `wdata=0x12341234`, req is held stable for 4 cycles, `o_write_done` pulses once.
- LW at addr 0x...01 → `o_misaligned` pulses in T+1, `o_dm_req` never rises, stall lasts 1 cycle.
- LHU with type 101 at 0x...00, ack never arrives, `TIMEOUT_CYCLES=4` → `o_timeout` pulses in T+5, `o_mem_data=0`, req drops.
- Reset asserted while BUSY → `o_dm_req` and `o_stall` go to 0 asynchronously and no pulse follows; the next LW completes normally.
- Two back-to-back SW/LW operations to the same word, with `i_mem_read` and `i_mem_write` both set on the first → the first is a store (`we=1`), and the second returns the stored word.
